// File: rtl/counter_monitor_if.sv
// rtl/counter_monitor_if.sv - sample/control and status bundle for counter_monitor
interface counter_monitor_if #(
   parameter int W     = 4,
   parameter int CNT_W = 8
) ();
   logic             en;
   logic             sel;
   logic [W-1:0]     cnt_in;
   logic             clr;
   logic             locked;
   logic             dir_up;
   logic             err_pulse;
   logic             err_sticky;
   logic [CNT_W-1:0] err_cnt;
   logic [CNT_W-1:0] wrap_cnt;

   modport master (
      output en, sel, cnt_in, clr,
      input  locked, dir_up, err_pulse, err_sticky, err_cnt, wrap_cnt
   );

   modport slave (
      input  en, sel, cnt_in, clr,
      output locked, dir_up, err_pulse, err_sticky, err_cnt, wrap_cnt
   );
endinterface

// File: rtl/counter_monitor.sv
// rtl/counter_monitor.sv - checks that an observed counter steps by one in its declared direction
module counter_monitor #(
   parameter int W        = 4,
   parameter int LOCK_LEN = 2,
   parameter int CNT_W    = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   counter_monitor_if.slave   bus
);
   typedef enum logic [1:0] {IDLE, ACQ, LOCKED} state_t;

   localparam logic [3:0]       LOCK_TGT = 4'(LOCK_LEN);
   localparam logic [W-1:0]     CNT_MAX  = {W{1'b1}};
   localparam logic [CNT_W-1:0] SAT_MAX  = {CNT_W{1'b1}};

   state_t           state, state_nxt;
   logic [3:0]       good_cnt, good_nxt;
   logic [W-1:0]     prev_cnt;
   logic             prev_sel;
   logic [W-1:0]     expected;
   logic             match;
   logic             wrap_step;
   logic             good_step;
   logic             wrap_det;
   logic             err_det;

   logic             locked_q;
   logic             dir_q;
   logic             pulse_q;
   logic             sticky_q;
   logic [CNT_W-1:0] err_q;
   logic [CNT_W-1:0] wrap_q;

   // Expected step uses the direction captured with the previous sample, so a reversal is legal.
   always_comb begin
      expected  = prev_sel ? (prev_cnt + W'(1)) : (prev_cnt - W'(1));
      match     = (bus.cnt_in == expected);
      wrap_step = prev_sel ? (prev_cnt == CNT_MAX) : (prev_cnt == '0);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         good_cnt <= '0;
      end else begin
         state    <= state_nxt;
         good_cnt <= good_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      good_nxt  = good_cnt;
      good_step = 1'b0;
      wrap_det  = 1'b0;
      err_det   = 1'b0;
      if (bus.en) begin
         case (state)
            IDLE: begin
               state_nxt = ACQ;
               good_nxt  = '0;
            end
            ACQ: begin
               if (match) begin
                  good_step = 1'b1;
                  if (good_cnt + 4'd1 == LOCK_TGT) begin
                     state_nxt = LOCKED;
                     good_nxt  = '0;
                  end else begin
                     good_nxt = good_cnt + 4'd1;
                  end
               end else begin
                  good_nxt = '0;
               end
            end
            LOCKED: begin
               if (match) begin
                  good_step = 1'b1;
                  wrap_det  = wrap_step;
               end else begin
                  err_det   = 1'b1;
                  state_nxt = ACQ;
                  good_nxt  = '0;
               end
            end
            default: begin
               state_nxt = IDLE;
               good_nxt  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prev_cnt <= '0;
         prev_sel <= 1'b0;
         locked_q <= 1'b0;
         dir_q    <= 1'b0;
         pulse_q  <= 1'b0;
         sticky_q <= 1'b0;
         err_q    <= '0;
         wrap_q   <= '0;
      end else begin
         locked_q <= (state_nxt == LOCKED);
         pulse_q  <= err_det;
         if (bus.en) begin
            prev_cnt <= bus.cnt_in;
            prev_sel <= bus.sel;
         end
         if (good_step) begin
            dir_q <= prev_sel;
         end
         // Clear wins over a same-cycle increment; the pulse itself still fires.
         if (bus.clr) begin
            err_q    <= '0;
            wrap_q   <= '0;
            sticky_q <= 1'b0;
         end else begin
            if (err_det) begin
               sticky_q <= 1'b1;
               if (err_q != SAT_MAX) begin
                  err_q <= err_q + CNT_W'(1);
               end
            end
            if (wrap_det && (wrap_q != SAT_MAX)) begin
               wrap_q <= wrap_q + CNT_W'(1);
            end
         end
      end
   end

   assign bus.locked     = locked_q;
   assign bus.dir_up     = dir_q;
   assign bus.err_pulse  = pulse_q;
   assign bus.err_sticky = sticky_q;
   assign bus.err_cnt    = err_q;
   assign bus.wrap_cnt   = wrap_q;
endmodule

// File: tb/tb_counter_monitor.sv
// tb/tb_counter_monitor.sv - directed vector table plus saturation and clear sequences
module tb_counter_monitor;
   logic clk = 1'b0;
   logic rst_n;

   counter_monitor_if #(.W(4), .CNT_W(8)) bus ();

   counter_monitor #(.W(4), .LOCK_LEN(2), .CNT_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       r, en, sel;
      logic [3:0] cnt;
      logic       clr;
      logic       l, d, p, s;
      logic [7:0] e, w;
   } vec_t;

   int checks = 0;
   int failures = 0;

   function automatic vec_t mk(int r, int en, int sel, int cnt, int clr,
                               int l, int d, int p, int s, int e, int w);
      vec_t v;
      v.r = r[0]; v.en = en[0]; v.sel = sel[0]; v.cnt = cnt[3:0]; v.clr = clr[0];
      v.l = l[0]; v.d = d[0]; v.p = p[0]; v.s = s[0]; v.e = e[7:0]; v.w = w[7:0];
      return v;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step(input logic r, input logic en, input logic sel,
                       input logic [3:0] cnt, input logic clr);
      rst_n = r; bus.en = en; bus.sel = sel; bus.cnt_in = cnt; bus.clr = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input int l, input int d, input int p,
                            input int s, input int e, input int w);
      check({tag, "_locked"},     int'(bus.locked),     l);
      check({tag, "_dir_up"},     int'(bus.dir_up),     d);
      check({tag, "_err_pulse"},  int'(bus.err_pulse),  p);
      check({tag, "_err_sticky"}, int'(bus.err_sticky), s);
      check({tag, "_err_cnt"},    int'(bus.err_cnt),    e);
      check({tag, "_wrap_cnt"},   int'(bus.wrap_cnt),   w);
   endtask

   vec_t vecs[26];

   initial begin
      int p;
      int m;
      logic [3:0] nib;

      //               r en sel cnt clr | l d p s  e w
      vecs[0]  = mk(0, 1, 1,  5, 0,  0, 0, 0, 0, 0, 0);
      vecs[1]  = mk(1, 1, 1,  0, 0,  0, 0, 0, 0, 0, 0);
      vecs[2]  = mk(1, 1, 1,  1, 0,  0, 1, 0, 0, 0, 0);
      vecs[3]  = mk(1, 1, 1,  2, 0,  1, 1, 0, 0, 0, 0);
      vecs[4]  = mk(1, 1, 1,  3, 0,  1, 1, 0, 0, 0, 0);
      vecs[5]  = mk(0, 1, 1,  4, 1,  0, 0, 0, 0, 0, 0);
      vecs[6]  = mk(1, 0, 0,  9, 0,  0, 0, 0, 0, 0, 0);
      vecs[7]  = mk(1, 1, 1, 12, 0,  0, 0, 0, 0, 0, 0);
      vecs[8]  = mk(1, 1, 1, 13, 0,  0, 1, 0, 0, 0, 0);
      vecs[9]  = mk(1, 1, 1, 14, 0,  1, 1, 0, 0, 0, 0);
      vecs[10] = mk(1, 1, 1, 15, 0,  1, 1, 0, 0, 0, 0);
      vecs[11] = mk(1, 1, 1,  0, 0,  1, 1, 0, 0, 0, 1);
      vecs[12] = mk(1, 1, 1,  1, 0,  1, 1, 0, 0, 0, 1);
      vecs[13] = mk(1, 0, 0,  7, 0,  1, 1, 0, 0, 0, 1);
      vecs[14] = mk(1, 1, 0,  2, 0,  1, 1, 0, 0, 0, 1);
      vecs[15] = mk(1, 1, 0,  1, 0,  1, 0, 0, 0, 0, 1);
      vecs[16] = mk(1, 1, 0,  0, 0,  1, 0, 0, 0, 0, 1);
      vecs[17] = mk(1, 1, 0, 15, 0,  1, 0, 0, 0, 0, 2);
      vecs[18] = mk(1, 1, 0, 14, 0,  1, 0, 0, 0, 0, 2);
      vecs[19] = mk(1, 1, 0,  9, 0,  0, 0, 1, 1, 1, 2);
      vecs[20] = mk(1, 1, 0,  8, 0,  0, 0, 0, 1, 1, 2);
      vecs[21] = mk(1, 1, 0,  7, 0,  1, 0, 0, 1, 1, 2);
      vecs[22] = mk(1, 1, 0,  0, 0,  0, 0, 1, 1, 2, 2);
      vecs[23] = mk(1, 1, 0,  5, 0,  0, 0, 0, 1, 2, 2);
      vecs[24] = mk(1, 1, 0,  4, 1,  0, 0, 0, 0, 0, 0);
      vecs[25] = mk(1, 1, 0,  3, 0,  1, 0, 0, 0, 0, 0);

      rst_n = 1'b0; bus.en = 1'b0; bus.sel = 1'b0; bus.cnt_in = '0; bus.clr = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      foreach (vecs[i]) begin
         step(vecs[i].r, vecs[i].en, vecs[i].sel, vecs[i].cnt, vecs[i].clr);
         check_all($sformatf("v%0d", i), vecs[i].l, vecs[i].d, vecs[i].p,
                   vecs[i].s, vecs[i].e, vecs[i].w);
      end

      // Locked going down at 3; reverse to up with a legal step.
      step(1, 1, 1, 4'd2, 0);
      check_all("rev_up", 1, 0, 0, 0, 0, 0);
      p = 2;

      // 300 locked mismatches, each followed by a two-step relock.
      for (int i = 0; i < 300; i++) begin
         m = (p + 5) % 16;
         step(1, 1, 1, 4'(m), 0);
         check($sformatf("sat%0d_err_cnt", i), int'(bus.err_cnt), (i + 1 > 255) ? 255 : i + 1);
         check($sformatf("sat%0d_pulse", i), int'(bus.err_pulse), 1);
         step(1, 1, 1, 4'((m + 1) % 16), 0);
         step(1, 1, 1, 4'((m + 2) % 16), 0);
         p = (m + 2) % 16;
      end
      check("sat_locked", int'(bus.locked), 1);
      check("sat_final", int'(bus.err_cnt), 255);

      // Clear coinciding with a mismatch: counters clear, pulse still fires.
      m = (p + 5) % 16;
      step(1, 1, 1, 4'(m), 1);
      check_all("clr_mm", 0, 1, 1, 0, 0, 0);

      // Disabled cycles with garbage input change nothing.
      for (int i = 0; i < 10; i++) begin
         nib = 4'($urandom_range(0, 15));
         step(1, 0, nib[0], nib, 0);
         check_all($sformatf("hold%0d", i), 0, 1, 0, 0, 0, 0);
      end

      // Captured sample survived the idle stretch: next step is a match, not an error.
      step(1, 1, 1, 4'((m + 1) % 16), 0);
      check_all("after_hold", 0, 1, 0, 0, 0, 0);
      step(1, 1, 1, 4'((m + 2) % 16), 0);
      check_all("relock", 1, 1, 0, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/counter_monitor.md
COUNTER_MONITOR -- requirements
Module: counter_monitor

Interface
REQ-001 Parameter: W, default 4, width of observed count.
REQ-002 Parameter: LOCK_LEN, default 2, consecutive good steps needed to reach LOCKED (range 1..15).
REQ-003 Parameter: CNT_W, default 8, width of error and wrap counters.
REQ-004 Port: clk  input  1  single clock; all logic on rising edge.
REQ-005 Port: rst_n  input  1  synchronous, active-low reset.
REQ-006 Port: en  input  1  sample strobe; inputs are observed only on edges with en=1.
REQ-007 Port: sel  input  1  direction of observed counter: 1=UP, 0=DOWN.
REQ-008 Port: cnt_in  input  W  observed counter value.
REQ-009 Port: clr  input  1  synchronous clear of err_cnt, wrap_cnt, err_sticky.
REQ-010 Port: locked  output  1  high while FSM is in LOCKED.
REQ-011 Port: dir_up  output  1  direction of the last good step (1=UP).
REQ-012 Port: err_pulse  output  1  one-cycle pulse per step error detected in LOCKED.
REQ-013 Port: err_sticky  output  1  set by any err_pulse; cleared only by clr or reset.
REQ-014 Port: err_cnt  output  CNT_W  saturating count of step errors.
REQ-015 Port: wrap_cnt  output  CNT_W  saturating count of good wrap-around steps in LOCKED.

Function
REQ-016 Block SHALL hold prev_cnt/prev_sel, captured from cnt_in/sel on every en=1 edge.
REQ-017 Expected value SHALL be prev_cnt+1 mod 2^W if prev_sel=1, else prev_cnt-1 mod 2^W; "match" means cnt_in equals expected.
REQ-018 FSM states SHALL be IDLE, ACQ, LOCKED; reset state IDLE.
REQ-019 IDLE: on en=1 edge, capture prev, clear good-step counter, go ACQ.
REQ-020 ACQ: on en=1 edge with match, increment good-step counter; on reaching LOCK_LEN, go LOCKED; on mismatch, reset good-step counter to 0 and stay in ACQ; no error reported in ACQ.
REQ-021 LOCKED: match stays LOCKED; mismatch asserts err_pulse next cycle, increments err_cnt, sets err_sticky, goes ACQ with good-step counter 0.
REQ-022 All state, counters and outputs SHALL hold when en=0; err_pulse SHALL be 0 on any cycle not following a LOCKED mismatch.
REQ-023 dir_up SHALL update to prev_sel on each match edge in ACQ or LOCKED, holding otherwise.
REQ-024 wrap_cnt SHALL increment on a match in LOCKED where step is (2^W-1)->0 with prev_sel=1 or 0->(2^W-1) with prev_sel=0.
REQ-025 err_cnt and wrap_cnt SHALL saturate at 2^CNT_W-1, never wrapping.
REQ-026 clr=1 SHALL zero err_cnt, wrap_cnt, err_sticky next cycle, with priority over a simultaneous increment/set; err_pulse still asserts; FSM and dir_up unaffected.
REQ-027 A sel change SHALL take effect for the step after it is captured (expected uses prev_sel), so a legitimate direction reversal produces no error.
REQ-028 Outputs are registered; latency from offending en edge to err_pulse/locked change is 1 cycle.

Reset
REQ-029 rst_n=0 at a clock edge SHALL force IDLE, locked=0, dir_up=0, err_pulse=0, err_sticky=0, err_cnt=0, wrap_cnt=0, prev_cnt=0, prev_sel=0, good-step counter 0, regardless of en/clr.
REQ-030 Reset asserted mid-operation SHALL discard lock state; relock requires 1+LOCK_LEN enabled samples after release.

Verification
REQ-031 Reset release, en=1, sel=1, cnt_in 0,1,2,3... -> locked=1 after third sample edge (+1 cycle); err_cnt=0.
REQ-032 Locked UP, cnt_in 14,15,0,1 -> wrap_cnt=1, no err_pulse; same in DOWN with 1,0,15,14 -> wrap_cnt=2.
REQ-033 Locked UP at 5, inject cnt_in=9 -> err_pulse for exactly one cycle, err_cnt=1, err_sticky=1, locked=0; resume 10,11 -> locked=1 again.
REQ-034 Locked UP, sel switches 1->0 at count 7: sequence 7(sel=0),6,5 -> no error, dir_up=0 after sample 6.
REQ-035 Force 300 mismatches with relock between -> err_cnt saturates at 255; clr with simultaneous mismatch -> err_cnt=0, err_sticky=0, err_pulse=1.
REQ-036 While locked, drive rst_n=0 one cycle -> all outputs zero next cycle; en=0 for 10 cycles with garbage cnt_in -> no state change.
